// File: rtl/tx_packet_arbiter_if.sv
// Packet-source side and UART-transmit side of the tx packet arbiter.
// The arbiter takes the master modport; the producers/UART model take the slave modport.
interface tx_packet_arbiter_if #(
    parameter int NUM_REQ   = 4,
    parameter int MAX_BYTES = 8,
    parameter int LEN_W     = 4
);
    logic [NUM_REQ-1:0]             req;
    logic [NUM_REQ*MAX_BYTES*8-1:0] req_data;
    logic [NUM_REQ*LEN_W-1:0]       req_len;
    logic [NUM_REQ-1:0]             grant;
    logic [NUM_REQ-1:0]             done;
    logic [7:0]                     tx_data;
    logic                           new_tx_data;
    logic                           tx_busy;
    logic                           busy;

    modport master (
        input  req, req_data, req_len, tx_busy,
        output grant, done, tx_data, new_tx_data, busy
    );

    modport slave (
        output req, req_data, req_len, tx_busy,
        input  grant, done, tx_data, new_tx_data, busy
    );
endinterface

// File: rtl/tx_packet_arbiter.sv
// Round-robin arbiter sharing one UART transmit byte channel among NUM_REQ packet
// sources; latches the winner's packet and streams it under tx_busy flow control.
module tx_packet_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int MAX_BYTES = 8,
    parameter int LEN_W     = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    tx_packet_arbiter_if.master bus
);
    localparam int PKT_W = MAX_BYTES * 8;
    localparam int WIN_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

    state_t state, state_next;

    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               new_tx_q, new_tx_d;
    logic [LEN_W-1:0]   idx_q, idx_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [PKT_W-1:0]   pkt_q, pkt_d;
    logic [WIN_W-1:0]   last_q, last_d;
    logic [WIN_W-1:0]   win_q, win_d;

    logic               found;
    logic [WIN_W-1:0]   win_idx;
    logic [LEN_W-1:0]   win_len_raw;
    logic [LEN_W-1:0]   win_len;
    logic [PKT_W-1:0]   win_data;
    logic [7:0]         cur_byte;
    int                 cand;

    // Search starts just after the previous winner, so a continuous requester cannot starve others.
    always_comb begin
        found       = 1'b0;
        win_idx     = '0;
        win_len_raw = '0;
        win_data    = '0;
        cand        = 0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand = (int'(last_q) + off) % NUM_REQ;
            if (!found && bus.req[cand]) begin
                found       = 1'b1;
                win_idx     = WIN_W'(cand);
                win_len_raw = bus.req_len[cand*LEN_W +: LEN_W];
                win_data    = bus.req_data[cand*PKT_W +: PKT_W];
            end
        end
        win_len = (win_len_raw > LEN_W'(MAX_BYTES)) ? LEN_W'(MAX_BYTES) : win_len_raw;
    end

    always_comb begin
        cur_byte = '0;
        for (int b = 0; b < MAX_BYTES; b++) begin
            if (idx_q == LEN_W'(b)) begin
                cur_byte = pkt_q[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (found) state_next = SEND;
            SEND: begin
                if (idx_q == len_q) begin
                    state_next = DONE;
                end else if (!bus.tx_busy) begin
                    state_next = GAP;
                end
            end
            GAP:  state_next = SEND;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Next values of the registered outputs and datapath; the strobe is only ever set from SEND.
    always_comb begin
        grant_d   = grant_q;
        done_d    = '0;
        tx_data_d = tx_data_q;
        new_tx_d  = 1'b0;
        idx_d     = idx_q;
        len_d     = len_q;
        pkt_d     = pkt_q;
        last_d    = last_q;
        win_d     = win_q;
        case (state)
            IDLE: begin
                if (found) begin
                    grant_d = NUM_REQ'(1) << win_idx;
                    pkt_d   = win_data;
                    len_d   = win_len;
                    idx_d   = '0;
                    win_d   = win_idx;
                end
            end
            SEND: begin
                if (idx_q != len_q && !bus.tx_busy) begin
                    tx_data_d = cur_byte;
                    new_tx_d  = 1'b1;
                    idx_d     = idx_q + LEN_W'(1);
                end
            end
            DONE: begin
                done_d  = grant_q;
                grant_d = '0;
                last_d  = win_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_q   <= '0;
            done_q    <= '0;
            tx_data_q <= '0;
            new_tx_q  <= 1'b0;
            idx_q     <= '0;
            len_q     <= '0;
            pkt_q     <= '0;
            last_q    <= WIN_W'(NUM_REQ - 1);
            win_q     <= '0;
        end else begin
            grant_q   <= grant_d;
            done_q    <= done_d;
            tx_data_q <= tx_data_d;
            new_tx_q  <= new_tx_d;
            idx_q     <= idx_d;
            len_q     <= len_d;
            pkt_q     <= pkt_d;
            last_q    <= last_d;
            win_q     <= win_d;
        end
    end

    assign bus.grant       = grant_q;
    assign bus.done        = done_q;
    assign bus.tx_data     = tx_data_q;
    assign bus.new_tx_data = new_tx_q;
    assign bus.busy        = (state != IDLE);
endmodule
